// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 32-word data RAM between the MEM
// stage (port 0, fixed priority) and the loader/debug port (port 1).
// Ports: clk, rst_n; per port N: reqN_i, weN_i, addrN_i, wdataN_i,
//   gntN_o, rvalidN_o, rdataN_o; stall0_o to the hazard unit;
//   RAM side: mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i.
// Build option: define DMEM_ARB_RR_EN for round-robin conflict
//   resolution instead of priority plus starvation counter.
module dmem_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [31:0]       addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              stall0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [31:0]       addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_P0,
        OWN_P1
    } owner_t;

    owner_t            rd_owner;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;
    logic              pick1;
    logic              both;

    // Only the word index reaches the RAM; the rest wraps away.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr0_i[31:ADDR_W], addr1_i[31:ADDR_W]};

    assign both = req0_i & req1_i;

`ifdef DMEM_ARB_RR_EN
    // last_gnt = 1 means port 1 won the most recent grant.
    logic last_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (gnt0_o) begin
            last_gnt <= 1'b0;
        end else if (gnt1_o) begin
            last_gnt <= 1'b1;
        end
    end

    assign pick1 = both ? ~last_gnt : req1_i;
`else
    assign pick1 = both ? (wait_cnt == 4'(MAX_WAIT)) : req1_i;
`endif

    assign gnt0_o   = req0_i & ~pick1;
    assign gnt1_o   = req1_i & pick1;
    assign stall0_o = req0_i & ~gnt0_o;

    always_comb begin
        mem_en_o    = gnt0_o | gnt1_o;
        mem_we_o    = 1'b0;
        mem_addr_o  = addr0_i[ADDR_W-1:0];
        mem_wdata_o = wdata0_i;
        if (gnt1_o) begin
            mem_we_o    = we1_i;
            mem_addr_o  = addr1_i[ADDR_W-1:0];
            mem_wdata_o = wdata1_i;
        end else if (gnt0_o) begin
            mem_we_o = we0_i;
        end
    end

    // Starvation counter; in round-robin builds it idles harmlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!req1_i || gnt1_o) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner <= OWN_NONE;
        end else if (gnt0_o && !we0_i) begin
            rd_owner <= OWN_P0;
        end else if (gnt1_o && !we1_i) begin
            rd_owner <= OWN_P1;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    // Hold registers keep the last delivered word for each port so a
    // non-owner's rdata stays put while the RAM serves the other port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (rd_owner == OWN_P0) hold0 <= mem_rdata_i;
            if (rd_owner == OWN_P1) hold1 <= mem_rdata_i;
        end
    end

    assign rvalid0_o = (rd_owner == OWN_P0);
    assign rvalid1_o = (rd_owner == OWN_P1);
    assign rdata0_o  = rvalid0_o ? mem_rdata_i : hold0;
    assign rdata1_o  = rvalid1_o ? mem_rdata_i : hold1;

endmodule
